// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter for four writers into the register bank.
//                It sequences each write as a one-cycle latch strobe, with a
//                full cycle of data setup before the rising latch edge and a
//                full cycle of hold after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [11:0]      req_sel,
    input  logic [31:0]      req_data,
    output logic [3:0]       gnt,
    output logic [3:0]       done,
    output logic             err,
    output logic [7:0]       bus_data,
    output logic [NREGS-1:0] latch,
    output logic             busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_STROBE = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    // 4 bits wide so that NREGS = 8 still compares correctly against a 3-bit select
    localparam logic [3:0] c_NREGS = 4'(NREGS);

    logic [1:0]       r_state, w_state_nxt;
    logic [1:0]       r_ptr, w_ptr_nxt;
    logic [2:0]       r_sel_q, w_sel_nxt;
    logic [3:0]       r_gnt, w_gnt_nxt;
    logic [3:0]       r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic [7:0]       r_bus, w_bus_nxt;
    logic [NREGS-1:0] r_latch, w_latch_nxt;
    logic             r_busy, w_busy_nxt;

    logic             w_found;
    logic [1:0]       w_win;
    logic             w_sel_ok;

    assign w_sel_ok = ({1'b0, r_sel_q} < c_NREGS);

    // Round-robin search: the first requesting index at or after the pointer
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int i = 0; i < 4; i++) begin
            if (!w_found && req[r_ptr + 2'(i)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(i);
            end
        end
    end

    // Next-state and next-output logic; every output comes straight from a flop
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel_q;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = 4'b0000;
        w_err_nxt   = 1'b0;
        w_bus_nxt   = r_bus;
        w_latch_nxt = '0;
        case (r_state)
            c_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt   = 4'b0001 << w_win;
                    w_sel_nxt   = req_sel[int'(w_win)*3 +: 3];
                    w_bus_nxt   = req_data[int'(w_win)*8 +: 8];
                    w_ptr_nxt   = w_win + 2'd1;
                    w_state_nxt = c_SETUP;
                end else begin
                    w_gnt_nxt = 4'b0000;
                end
            end
            c_SETUP: begin
                // An out-of-range select matches no strobe, so nothing fires
                for (int k = 0; k < NREGS; k++) begin
                    w_latch_nxt[k] = (r_sel_q == 3'(k));
                end
                w_state_nxt = c_STROBE;
            end
            c_STROBE: begin
                w_done_nxt  = r_gnt;
                w_err_nxt   = !w_sel_ok;
                w_state_nxt = c_HOLD;
            end
            c_HOLD: begin
                w_gnt_nxt   = 4'b0000;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_gnt_nxt   = 4'b0000;
                w_state_nxt = c_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != c_IDLE);
    end

    // State and output registers; reset drops every strobe without an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_ptr   <= 2'd0;
            r_sel_q <= 3'd0;
            r_gnt   <= 4'b0000;
            r_done  <= 4'b0000;
            r_err   <= 1'b0;
            r_bus   <= 8'h00;
            r_latch <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel_q <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_bus   <= w_bus_nxt;
            r_latch <= w_latch_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign err      = r_err;
    assign bus_data = r_bus;
    assign latch    = r_latch;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Self-checking bench for reg_write_arbiter (NREGS = 5) with a
//                behavioural register bank capturing on latch rising edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int NREGS = 5;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [11:0]      req_sel;
    logic [31:0]      req_data;
    logic [3:0]       gnt;
    logic [3:0]       done;
    logic             err;
    logic [7:0]       bus_data;
    logic [NREGS-1:0] latch;
    logic             busy;

    reg_write_arbiter #(.NREGS(NREGS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_sel  (req_sel),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .bus_data (bus_data),
        .latch    (latch),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: captures bus_data on each rising latch bit
    logic [7:0]       bank [NREGS];
    logic [NREGS-1:0] prev_latch;
    int               cap_total = 0;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) bank[k] = 8'h00;
            prev_latch = '0;
        end else begin
            for (int k = 0; k < NREGS; k++) begin
                if (latch[k] && !prev_latch[k]) begin
                    bank[k]   = bus_data;
                    cap_total = cap_total + 1;
                end
            end
            prev_latch = latch;
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [11:0] sel;
        logic [31:0] data;
        logic [3:0]  exp_gnt;
        logic [4:0]  exp_latch;
        logic        exp_err;
        logic [7:0]  exp_bus;
        logic        chk_gap;
    } vec_t;

    typedef struct {
        logic [4:0] latch;
        logic [7:0] data;
        int         caps_before;
    } sb_t;

    sb_t  sb [$];
    vec_t vecs [10];
    int   n_vec = 0;
    int   n_err = 0;
    int   last_gnt_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one request at a negedge and follows its transaction through HOLD
    task automatic do_txn(input vec_t v);
        int  t;
        sb_t e;
        req      = v.req;
        req_sel  = v.sel;
        req_data = v.data;
        sb.push_back('{latch: v.exp_latch, data: v.exp_bus, caps_before: cap_total});
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (gnt == 4'b0000 && t < 8);
        if (gnt == 4'b0000) begin
            chk("grant_timeout", 32'(gnt), 32'(v.exp_gnt));
            void'(sb.pop_front());
            return;
        end
        chk("gnt_E0", 32'(gnt), 32'(v.exp_gnt));
        chk("bus_E0", 32'(bus_data), 32'(v.exp_bus));
        chk("busy_E0", 32'(busy), 32'd1);
        chk("latch_E0", 32'(latch), 32'd0);
        if (v.chk_gap) chk("grant_gap", 32'(cyc - last_gnt_cyc), 32'd4);
        last_gnt_cyc = cyc;
        // Data changes after the grant edge must not reach the bus
        req_data = ~v.data;
        @(negedge clk);
        chk("latch_E1", 32'(latch), 32'(v.exp_latch));
        chk("done_E1", 32'(done), 32'd0);
        @(negedge clk);
        chk("latch_E2", 32'(latch), 32'd0);
        chk("done_E2", 32'(done), 32'(v.exp_gnt));
        chk("err_E2", 32'(err), 32'(v.exp_err));
        chk("bus_E2", 32'(bus_data), 32'(v.exp_bus));
        e = sb.pop_front();
        chk("captures", 32'(cap_total - e.caps_before), (e.latch != 5'd0) ? 32'd1 : 32'd0);
        for (int k = 0; k < NREGS; k++) begin
            if (e.latch[k]) chk("reg_value", 32'(bank[k]), 32'(e.data));
        end
    endtask

    initial begin
        vec_t post;
        // Four requesters continuously: grant order 0,1,2,3 then wrap tests
        vecs[0] = '{4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h44332211, 4'b0001, 5'h01, 1'b0, 8'h11, 1'b0};
        vecs[1] = '{4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h44332211, 4'b0010, 5'h02, 1'b0, 8'h22, 1'b1};
        vecs[2] = '{4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h44332211, 4'b0100, 5'h04, 1'b0, 8'h33, 1'b1};
        vecs[3] = '{4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h44332211, 4'b1000, 5'h08, 1'b0, 8'h44, 1'b1};
        vecs[4] = '{4'h9, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h44332211, 4'b0001, 5'h01, 1'b0, 8'h11, 1'b1};
        vecs[5] = '{4'h9, {3'd3, 3'd2, 3'd1, 3'd0}, 32'h44332211, 4'b1000, 5'h08, 1'b0, 8'h44, 1'b1};
        vecs[6] = '{4'h2, {3'd0, 3'd0, 3'd2, 3'd0}, 32'h0000A500, 4'b0010, 5'h04, 1'b0, 8'hA5, 1'b1};
        vecs[7] = '{4'h4, {3'd0, 3'd6, 3'd0, 3'd0}, 32'h00C30000, 4'b0100, 5'h00, 1'b1, 8'hC3, 1'b1};
        vecs[8] = '{4'h1, {3'd0, 3'd0, 3'd0, 3'd4}, 32'h0000007E, 4'b0001, 5'h10, 1'b0, 8'h7E, 1'b1};
        vecs[9] = '{4'h3, {3'd0, 3'd0, 3'd1, 3'd0}, 32'h00009966, 4'b0010, 5'h02, 1'b0, 8'h99, 1'b1};

        rst_n    = 1'b0;
        req      = 4'b0000;
        req_sel  = 12'h000;
        req_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_latch", 32'(latch), 32'd0);
        chk("rst_bus", 32'(bus_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", {27'd0, done, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) do_txn(vecs[i]);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_gnt", 32'(gnt), 32'd0);

        // Reset in the middle of a write, while the strobe is high
        req      = 4'b0100;
        req_sel  = {3'd0, 3'd3, 3'd0, 3'd0};
        req_data = 32'h005A0000;
        begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (gnt == 4'b0000 && t < 8);
        end
        chk("mid_gnt", 32'(gnt), 32'b0100);
        @(negedge clk);
        chk("mid_latch", 32'(latch), 32'h08);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_latch", 32'(latch), 32'd0);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bus", 32'(bus_data), 32'd0);
        chk("mid_rst_done_err", {27'd0, done, err}, 32'd0);
        req = 4'b0000;
        @(negedge clk);
        chk("mid_rst_reg3", 32'(bank[3]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Pointer restarts at requester 0
        post = '{4'h3, {3'd0, 3'd0, 3'd1, 3'd0}, 32'h0000BBAA, 4'b0001, 5'h01, 1'b0, 8'hAA, 1'b0};
        do_txn(post);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
